// File: rtl/reverb_param_controller_pkg.sv
// Shared constants and types for the reverb parameter controller: register map,
// fixed-point format and the commit sequencer states.
package reverb_param_controller_pkg;
    localparam int FIXED_POINT            = 8;
    localparam int MAX_FILTER_FIFO_LENGTH = 1024;
    localparam int TAU_BASE               = 0;
    localparam int GAIN_BASE              = 6;
    localparam int NREG                   = 13;
    localparam int NTAU                   = 6;
    localparam int NGAIN                  = 7;
    localparam int GAIN_MAX               = (1 << FIXED_POINT) - 1;

    typedef enum logic [1:0] {IDLE, PENDING, MUTE, RAMP} rpc_state_e;
endpackage

// File: rtl/reverb_param_controller_gain_slew.sv
// One gain channel's slew step: next value moves toward the target by at most STEP.
module gain_slew #(
    parameter int W    = 32,
    parameter int STEP = 2
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] nxt,
    output logic         done
);
    logic signed [W-1:0] diff;

    always_comb begin
        diff = $signed(tgt) - $signed(cur);
        if (diff > STEP)
            nxt = cur + W'(STEP);
        else if (diff < -STEP)
            nxt = cur - W'(STEP);
        else
            nxt = tgt;
        done = (nxt == tgt);
    end
endmodule

// File: rtl/reverb_param_controller.sv
// Shadow/active parameter controller for the reverberator: buffered writes, glitch-free
// commits (mute window on delay change, gain slewing otherwise).
module reverb_param_controller
    import reverb_param_controller_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int MAXDELAY     = MAX_FILTER_FIFO_LENGTH,
    parameter int GAIN_STEP    = 2,
    parameter int MUTE_SAMPLES = 64,
    localparam int W           = WIDTH + FIXED_POINT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [3:0]             wr_addr,
    input  logic [W-1:0]           wr_data,
    input  logic                   commit,
    output logic [NTAU-1:0][W-1:0] tau,
    output logic [NGAIN-1:0][W-1:0] gain,
    output logic                   rev_enable,
    output logic                   busy,
    output logic                   wr_err
);
    localparam int CW = $clog2(MUTE_SAMPLES + 1);
    localparam logic [W-1:0] ONE = W'(1) << FIXED_POINT;

    rpc_state_e state, state_nxt;

    logic [NTAU-1:0][W-1:0]  shadow_tau;
    logic [NGAIN-1:0][W-1:0] shadow_gain, tgt_gain, gain_nxt;
    logic [NGAIN-1:0]        slew_done;
    logic [CW-1:0]           cnt;
    logic                    flag;
    logic                    latch_tgt, mute_load, mute_dec, en_set, ramp_step;
    logic                    flag_set, flag_clr;
    logic                    wr_fire;
    logic [2:0]              tidx, gidx;

    function automatic logic [W-1:0] clamp_tau(input logic [W-1:0] d);
        logic signed [W-1:0] ip;
        ip = $signed(d) >>> FIXED_POINT;
        if (ip < 1)
            return ONE;
        if (ip > MAXDELAY - 1)
            return W'(MAXDELAY - 1) << FIXED_POINT;
        return {d[W-1:FIXED_POINT], {FIXED_POINT{1'b0}}};
    endfunction

    function automatic logic [W-1:0] clamp_gain(input logic [W-1:0] d);
        if (d[W-1])
            return '0;
        if (d > W'(GAIN_MAX))
            return W'(GAIN_MAX);
        return d;
    endfunction

    assign wr_ready = (state != PENDING);
    assign busy     = (state != IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign tidx     = 3'(wr_addr - 4'(TAU_BASE));
    assign gidx     = 3'(wr_addr - 4'(GAIN_BASE));

    for (genvar g = 0; g < NGAIN; g++) begin : g_slew
        gain_slew #(.W(W), .STEP(GAIN_STEP)) u_slew (
            .cur  (gain[g]),
            .tgt  (tgt_gain[g]),
            .nxt  (gain_nxt[g]),
            .done (slew_done[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A commit always wins over a same-clk tick, so a tick never latches a
    // commit that was only just requested.
    always_comb begin
        state_nxt = state;
        latch_tgt = 1'b0;
        mute_load = 1'b0;
        mute_dec  = 1'b0;
        en_set    = 1'b0;
        ramp_step = 1'b0;
        flag_set  = 1'b0;
        flag_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (commit || flag) begin
                    state_nxt = PENDING;
                    flag_clr  = 1'b1;
                end
            end
            PENDING: begin
                flag_set = commit;
                if (sample_tick) begin
                    latch_tgt = 1'b1;
                    if (shadow_tau != tau) begin
                        state_nxt = MUTE;
                        mute_load = 1'b1;
                    end else begin
                        state_nxt = RAMP;
                    end
                end
            end
            MUTE: begin
                flag_set = commit;
                if (sample_tick) begin
                    mute_dec = 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_nxt = RAMP;
                        en_set    = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (commit || flag) begin
                    state_nxt = PENDING;
                    flag_clr  = 1'b1;
                end else if (sample_tick) begin
                    ramp_step = 1'b1;
                    if (&slew_done)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAU; i++) begin
                tau[i]        <= ONE;
                shadow_tau[i] <= ONE;
            end
            gain        <= '0;
            shadow_gain <= '0;
            tgt_gain    <= '0;
            rev_enable  <= 1'b0;
            cnt         <= '0;
            flag        <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            if (wr_fire) begin
                if (wr_addr < 4'(GAIN_BASE))
                    shadow_tau[tidx] <= clamp_tau(wr_data);
                else if (wr_addr < 4'(NREG))
                    shadow_gain[gidx] <= clamp_gain(wr_data);
                else
                    wr_err <= 1'b1;
            end
            if (flag_set)
                flag <= 1'b1;
            else if (flag_clr)
                flag <= 1'b0;
            if (latch_tgt)
                tgt_gain <= shadow_gain;
            // Delay change: jump straight to the new set while the core is muted.
            if (mute_load) begin
                tau        <= shadow_tau;
                gain       <= shadow_gain;
                rev_enable <= 1'b0;
                cnt        <= CW'(MUTE_SAMPLES);
            end
            if (mute_dec)
                cnt <= cnt - CW'(1);
            if (en_set)
                rev_enable <= 1'b1;
            if (ramp_step)
                gain <= gain_nxt;
        end
    end
endmodule

// File: tb/tb_reverb_param_controller.sv
// Self-checking bench for reverb_param_controller: directed scenarios plus randomized
// gain commits checked against a per-tick behavioural model.
module tb_reverb_param_controller;
    localparam int W    = 32;
    localparam int MAXD = reverb_param_controller_pkg::MAX_FILTER_FIFO_LENGTH;

    logic clk = 0, rst = 1;
    logic sample_tick = 0, wr_valid = 0, commit = 0;
    logic [3:0] wr_addr = 0;
    logic [W-1:0] wr_data = 0;
    logic wr_ready, rev_enable, busy, wr_err;
    logic [5:0][W-1:0] tau;
    logic [6:0][W-1:0] gain;

    int errors = 0, checks = 0;
    int m_tau[6], m_gain[7], m_sh_tau[6], m_sh_gain[7];

    reverb_param_controller dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .tau(tau), .gain(gain), .rev_enable(rev_enable), .busy(busy), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic int mclamp_tau(input int d);
        int ip;
        if (d < 256) return 256;
        ip = d / 256;
        if (ip > MAXD - 1) ip = MAXD - 1;
        return ip * 256;
    endfunction

    function automatic int mclamp_gain(input int d);
        if (d < 0) return 0;
        if (d > 255) return 255;
        return d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) begin m_tau[i] = 256; m_sh_tau[i] = 256; end
        for (int i = 0; i < 7; i++) begin m_gain[i] = 0; m_sh_gain[i] = 0; end
    endfunction

    function automatic void model_write(input int a, input int d);
        if (a < 6) m_sh_tau[a] = mclamp_tau(d);
        else if (a < 13) m_sh_gain[a-6] = mclamp_gain(d);
    endfunction

    function automatic void model_apply();
        for (int i = 0; i < 6; i++) m_tau[i] = m_sh_tau[i];
        for (int i = 0; i < 7; i++) m_gain[i] = m_sh_gain[i];
    endfunction

    task automatic cyc(input bit tk, input bit cm);
        @(negedge clk); sample_tick = tk; commit = cm;
        @(posedge clk); #1; sample_tick = 0; commit = 0;
    endtask

    task automatic tick();
        cyc(1, 0); cyc(0, 0);
    endtask

    task automatic wr(input int a, input int d, input bit cm);
        @(negedge clk); wr_valid = 1; wr_addr = 4'(a); wr_data = W'(d); commit = cm;
        @(posedge clk); #1; wr_valid = 0; commit = 0;
        model_write(a, d);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s: busy=%b after %0d ticks, required 0", nm, busy, n);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 0 || wr_ready !== 1 || rev_enable !== 0 || wr_err !== 0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b rdy=%b en=%b err=%b, required 0 1 0 0", busy, wr_ready, rev_enable, wr_err);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tau[i] !== 32'h100) begin errors++; $display("FAIL reset_tau%0d: got %h, required 100", i, tau[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (gain[i] !== 0) begin errors++; $display("FAIL reset_gain%0d: got %h, required 0", i, gain[i]); end
        end
    endtask

    task automatic test_mute();
        int n = 0, guard = 0;
        wr(2, 32'h1F400, 0);
        cyc(0, 1);
        checks++;
        if (busy !== 1 || wr_ready !== 0) begin
            errors++; $display("FAIL mute_pending: busy=%b rdy=%b, required 1 0", busy, wr_ready);
        end
        tick();
        checks++;
        if (tau[2] !== 32'h1F400 || rev_enable !== 0) begin
            errors++; $display("FAIL mute_entry: tau2=%h en=%b, required 1f400 0", tau[2], rev_enable);
        end
        if (rev_enable === 0) n = 1;
        while (rev_enable === 0 && guard < 200) begin
            tick(); guard++;
            if (rev_enable === 0) n++;
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL mute_len: muted %0d ticks, required 64", n); end
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL mute_ramp: busy=%b, required 1", busy); end
        tick();
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL mute_idle: busy=%b, required 0", busy); end
        model_apply();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tau[i] !== W'(m_tau[i])) begin errors++; $display("FAIL mute_tau%0d: got %h, required %h", i, tau[i], m_tau[i]); end
        end
    endtask

    task automatic test_ramp();
        int exp = 0, n = 0;
        wr(6, 32'hB3, 0);
        cyc(0, 1);
        tick();
        checks++;
        if (gain[0] !== 0 || busy !== 1) begin
            errors++; $display("FAIL ramp_latch: gain0=%h busy=%b, required 0 1", gain[0], busy);
        end
        while (gain[0] !== 32'hB3 && n < 200) begin
            tick(); n++;
            exp = (exp + 2 > 'hB3) ? 'hB3 : exp + 2;
            checks++;
            if (gain[0] !== W'(exp) || rev_enable !== 1) begin
                errors++; $display("FAIL ramp_step%0d: gain0=%h en=%b, required %h 1", n, gain[0], rev_enable, exp);
            end
        end
        checks++;
        if (n != 90) begin errors++; $display("FAIL ramp_len: reached target after %0d ticks, required 90", n); end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL ramp_idle: busy=%b, required 0", busy); end
        model_apply();
    endtask

    task automatic test_clamp();
        wr(0, 0, 0);
        wr(1, (MAXD + 5) * 256, 0);
        wr(9, 'h180, 0);
        wr(10, -5, 0);
        cyc(0, 1);
        tick();
        checks++;
        if (tau[0] !== 32'h100 || tau[1] !== W'((MAXD - 1) * 256)) begin
            errors++; $display("FAIL clamp_tau: tau0=%h tau1=%h, required 100 %h", tau[0], tau[1], (MAXD - 1) * 256);
        end
        checks++;
        if (gain[3] !== 32'hFF || gain[4] !== 0 || rev_enable !== 0) begin
            errors++; $display("FAIL clamp_gain: g3=%h g4=%h en=%b, required ff 0 0", gain[3], gain[4], rev_enable);
        end
        wait_idle("clamp_done", 200);
        model_apply();
    endtask

    task automatic test_pending_write();
        int n = 0;
        logic [5:0][W-1:0] st;
        logic [6:0][W-1:0] sg;
        @(negedge clk); commit = 1;
        @(posedge clk); #1; commit = 0; wr_valid = 1; wr_addr = 11; wr_data = 32'h40;
        @(posedge clk); #1;
        checks++;
        if (wr_ready !== 0) begin errors++; $display("FAIL pend_ready: rdy=%b, required 0", wr_ready); end
        @(negedge clk); sample_tick = 1;
        @(posedge clk); #1; sample_tick = 0;
        checks++;
        if (wr_ready !== 1) begin errors++; $display("FAIL pend_release: rdy=%b, required 1", wr_ready); end
        @(posedge clk); #1; wr_valid = 0;
        model_write(11, 'h40);
        tick();
        cyc(0, 1);
        tick();
        while (busy === 1 && n < 100) begin tick(); n++; end
        checks++;
        if (gain[5] !== 32'h40) begin errors++; $display("FAIL pend_write: gain5=%h, required 40", gain[5]); end
        model_apply();
        st = tau; sg = gain;
        wr(14, 'h55, 0);
        checks++;
        if (wr_err !== 1) begin errors++; $display("FAIL err_pulse: wr_err=%b, required 1", wr_err); end
        cyc(0, 0);
        checks++;
        if (wr_err !== 0) begin errors++; $display("FAIL err_clear: wr_err=%b, required 0", wr_err); end
        cyc(0, 1);
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tau[i] !== W'(m_tau[i])) begin errors++; $display("FAIL err_tau%0d: got %h, required %h (was %h)", i, tau[i], m_tau[i], st[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (gain[i] !== W'(m_gain[i])) begin errors++; $display("FAIL err_gain%0d: got %h, required %h (was %h)", i, gain[i], m_gain[i], sg[i]); end
        end
    endtask

    task automatic test_commit_in_mute();
        int guard = 0;
        wr(3, 'h500, 0);
        cyc(0, 1);
        tick();
        model_apply();
        for (int i = 0; i < 5; i++) tick();
        wr(4, 'h600, 0);
        wr(8, 'h30, 0);
        cyc(0, 1);
        while (rev_enable === 0 && guard < 200) begin tick(); guard++; end
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL cim_busy: busy=%b, required 1", busy); end
        tick();
        checks++;
        if (tau[4] !== 32'h600 || gain[2] !== 32'h30 || rev_enable !== 0) begin
            errors++; $display("FAIL cim_reapply: tau4=%h g2=%h en=%b, required 600 30 0", tau[4], gain[2], rev_enable);
        end
        model_apply();
        wait_idle("cim_done", 300);
        checks++;
        if (rev_enable !== 1 || tau[3] !== 32'h500) begin
            errors++; $display("FAIL cim_final: en=%b tau3=%h, required 1 500", rev_enable, tau[3]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int nw, d, guard;
            bit diff;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                d = int'($urandom_range(0, 400)) - 50;
                wr(6 + $urandom_range(0, 6), d, (k == nw - 1) && (r % 2 == 0));
            end
            if (r % 2 == 1) begin
                cyc(1, 1);
                checks++;
                if (busy !== 1) begin errors++; $display("FAIL rnd%0d_tickcommit: busy=%b, required 1", r, busy); end
            end
            tick();
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (gain[i] !== W'(m_gain[i])) begin errors++; $display("FAIL rnd%0d_latch_g%0d: got %h, required %h", r, i, gain[i], m_gain[i]); end
            end
            guard = 0;
            do begin
                tick(); guard++;
                diff = 0;
                for (int i = 0; i < 7; i++) begin
                    int dd = m_sh_gain[i] - m_gain[i];
                    if (dd > 2) dd = 2;
                    if (dd < -2) dd = -2;
                    m_gain[i] += dd;
                    if (m_gain[i] != m_sh_gain[i]) diff = 1;
                    checks++;
                    if (gain[i] !== W'(m_gain[i])) begin errors++; $display("FAIL rnd%0d_t%0d_g%0d: got %h, required %h", r, guard, i, gain[i], m_gain[i]); end
                end
            end while (diff && guard < 400);
            checks++;
            if (busy !== 0 || rev_enable !== 1) begin
                errors++; $display("FAIL rnd%0d_idle: busy=%b en=%b, required 0 1", r, busy, rev_enable);
            end
        end
    endtask

    task automatic test_reset_mid_mute();
        wr(5, 'h700, 0);
        cyc(0, 1);
        tick();
        for (int i = 0; i < 10; i++) tick();
        @(posedge clk); #3; rst = 1; #1;
        model_reset();
        checks++;
        if (busy !== 0 || wr_ready !== 1 || rev_enable !== 0 || wr_err !== 0) begin
            errors++; $display("FAIL rst_ctl: busy=%b rdy=%b en=%b err=%b, required 0 1 0 0", busy, wr_ready, rev_enable, wr_err);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tau[i] !== 32'h100) begin errors++; $display("FAIL rst_tau%0d: got %h, required 100", i, tau[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (gain[i] !== 0) begin errors++; $display("FAIL rst_gain%0d: got %h, required 0", i, gain[i]); end
        end
        @(negedge clk); rst = 0;
        cyc(0, 1);
        tick(); tick();
        checks++;
        if (busy !== 0 || tau[5] !== 32'h100 || rev_enable !== 0) begin
            errors++; $display("FAIL rst_noresidue: busy=%b tau5=%h en=%b, required 0 100 0", busy, tau[5], rev_enable);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst = 0;
        test_mute();
        test_ramp();
        test_clamp();
        test_pending_write();
        test_commit_in_mute();
        test_random();
        test_reset_mid_mute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
